// File: rtl/f1_start_sequencer.sv
// Tick generator for the F1 start-lights FSM: eight evenly spaced lighting ticks,
// a pseudo-random hold, then a ninth "lights out" tick.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for trigger; tick_count holds the last sequence
// LIGHT | counting PERIOD cycles between lighting ticks 1..8
// HOLD  | counting the random hold before the lights-out tick
module f1_start_sequencer #(
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned PERIOD    = 1000,
    parameter int unsigned HOLD_MIN  = 100,
    parameter int unsigned HOLD_STEP = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trigger,
    output logic       tick,
    output logic       busy,
    output logic       lights_out,
    output logic [3:0] tick_count,
    output logic [6:0] lfsr_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LIGHT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] PERIOD_LOAD = CNT_W'(PERIOD - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [3:0]       tc_nxt;
    logic [6:0]       lfsr;
    logic [CNT_W-1:0] hold_load;
    logic             cnt_zero;

    // Hold length is formed at full 32-bit width and only then narrowed to the counter.
    assign hold_load = CNT_W'(32'(HOLD_MIN) + 32'(lfsr) * 32'(HOLD_STEP) - 32'd1);
    assign cnt_zero  = (cnt == '0);
    assign lfsr_out  = lfsr;

    // Free-running x^7+x^6+1 sequence; the all-zero state is unreachable from 7'h01.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= 7'h01;
        end else begin
            lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            tick_count <= 4'd0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            tick_count <= tc_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        tc_nxt     = tick_count;
        tick       = 1'b0;
        busy       = 1'b0;
        lights_out = 1'b0;
        case (state)
            IDLE: begin
                if (trigger) begin
                    state_nxt = LIGHT;
                    cnt_nxt   = PERIOD_LOAD;
                    tc_nxt    = 4'd0;
                end
            end
            LIGHT: begin
                busy = 1'b1;
                if (cnt_zero) begin
                    tick   = 1'b1;
                    tc_nxt = tick_count + 4'd1;
                    if (tick_count == 4'd7) begin
                        state_nxt = HOLD;
                        cnt_nxt   = hold_load;
                    end else begin
                        cnt_nxt = PERIOD_LOAD;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            HOLD: begin
                busy = 1'b1;
                if (cnt_zero) begin
                    tick       = 1'b1;
                    lights_out = 1'b1;
                    tc_nxt     = 4'd9;
                    state_nxt  = IDLE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_f1_start_sequencer.sv
// Directed bench for f1_start_sequencer with PERIOD=4, HOLD_MIN=3, HOLD_STEP=2,
// plus a reference LFSR and a lights-FSM model driven by tick.
module tb_f1_start_sequencer;

    localparam int PERIOD    = 4;
    localparam int HOLD_MIN  = 3;
    localparam int HOLD_STEP = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       trigger;
    logic       tick;
    logic       busy;
    logic       lights_out;
    logic [3:0] tick_count;
    logic [6:0] lfsr_out;

    f1_start_sequencer #(
        .CNT_W    (16),
        .PERIOD   (PERIOD),
        .HOLD_MIN (HOLD_MIN),
        .HOLD_STEP(HOLD_STEP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .trigger   (trigger),
        .tick      (tick),
        .busy      (busy),
        .lights_out(lights_out),
        .tick_count(tick_count),
        .lfsr_out  (lfsr_out)
    );

    always #5 clk = ~clk;

    logic [6:0] m_lfsr;
    logic [7:0] m_lights;

    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= 7'h01;
        else     m_lfsr <= {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
    end

    // Start-lights FSM: S0..S8 as a thermometer code, en from tick; S8 + en returns to S0.
    always @(posedge clk or posedge rst) begin
        if (rst)        m_lights <= 8'h00;
        else if (tick)  m_lights <= (m_lights == 8'hFF) ? 8'h00 : {m_lights[6:0], 1'b1};
    end

    typedef struct {
        logic       trig;
        logic       tick;
        logic       busy;
        logic [3:0] tc;
        logic [7:0] lights;
    } vec_t;

    vec_t       tbl [33];
    logic [6:0] hand [6] = '{7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h41};

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Row i is the sample just after edge k+i, where k is the edge that accepts trigger.
    task automatic run_seq(input bit mask10, input bit hold_trig, input int end_mode,
                           output int l_val);
        int h;
        l_val = 0;
        for (int i = 0; i < 33; i++) begin
            trigger = tbl[i].trig | hold_trig | (mask10 && i == 10);
            step;
            chk($sformatf("row%0d tick", i), {31'd0, tick}, {31'd0, tbl[i].tick});
            chk($sformatf("row%0d busy", i), {31'd0, busy}, {31'd0, tbl[i].busy});
            chk($sformatf("row%0d lights_out", i), {31'd0, lights_out}, 32'd0);
            chk($sformatf("row%0d tick_count", i), {28'd0, tick_count}, {28'd0, tbl[i].tc});
            chk($sformatf("row%0d lights", i), {24'd0, m_lights}, {24'd0, tbl[i].lights});
            if (i == 31) l_val = int'(m_lfsr);
        end
        h = HOLD_MIN + l_val * HOLD_STEP;
        for (int j = 1; j < h; j++) begin
            step;
            chk($sformatf("hold%0d tick", j), {31'd0, tick}, {31'd0, (j == h - 1)});
            chk($sformatf("hold%0d lights_out", j), {31'd0, lights_out}, {31'd0, (j == h - 1)});
            chk($sformatf("hold%0d busy", j), {31'd0, busy}, 32'd1);
            chk($sformatf("hold%0d tick_count", j), {28'd0, tick_count}, 32'd8);
        end
        trigger = (end_mode != 0);
        step;
        chk("end busy", {31'd0, busy}, 32'd0);
        chk("end tick", {31'd0, tick}, 32'd0);
        chk("end lights_out", {31'd0, lights_out}, 32'd0);
        chk("end tick_count", {28'd0, tick_count}, 32'd9);
        chk("end lights", {24'd0, m_lights}, 32'd0);
        if (end_mode == 1) begin
            trigger = 1'b0;
            step;
            chk("no queue busy", {31'd0, busy}, 32'd0);
            chk("no queue tick_count", {28'd0, tick_count}, 32'd9);
        end
    endtask

    initial begin
        int  first_rep;
        bit  zero_seen;
        bit  idle_bad;
        int  l1, l2, l3, h;

        for (int i = 0; i < 33; i++) begin
            tbl[i].trig   = (i == 0);
            tbl[i].tick   = ((i % 4) == 3);
            tbl[i].busy   = 1'b1;
            tbl[i].tc     = 4'(i / 4);
            tbl[i].lights = 8'((1 << (i / 4)) - 1);
        end

        rst     = 1'b1;
        trigger = 1'b0;
        #2;
        chk("reset tick", {31'd0, tick}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset lights_out", {31'd0, lights_out}, 32'd0);
        chk("reset tick_count", {28'd0, tick_count}, 32'd0);
        chk("reset lfsr", {25'd0, lfsr_out}, 32'h01);
        step;
        chk("reset lfsr held", {25'd0, lfsr_out}, 32'h01);
        rst = 1'b0;

        first_rep = 0;
        zero_seen = 1'b0;
        idle_bad  = 1'b0;
        for (int i = 1; i <= 127; i++) begin
            step;
            chk($sformatf("lfsr step%0d", i), {25'd0, lfsr_out}, {25'd0, m_lfsr});
            if (i <= 6) chk($sformatf("lfsr hand%0d", i), {25'd0, lfsr_out}, {25'd0, hand[i-1]});
            if (lfsr_out == 7'h00) zero_seen = 1'b1;
            if (first_rep == 0 && lfsr_out == 7'h01) first_rep = i;
            if (tick || busy || lights_out) idle_bad = 1'b1;
        end
        chk("lfsr never zero", {31'd0, zero_seen}, 32'd0);
        chk("lfsr period", first_rep, 127);
        chk("idle without trigger", {31'd0, idle_bad}, 32'd0);

        run_seq(1'b0, 1'b0, 1, l1);
        run_seq(1'b1, 1'b0, 2, l2);
        run_seq(1'b0, 1'b1, 0, l3);
        chk("hold values differ", {31'd0, (l1 != l2 || l2 != l3 || l1 != l3)}, 32'd1);

        // Abort in the very cycle the lights-out tick is being driven.
        trigger = 1'b1;
        step;
        trigger = 1'b0;
        h = 0;
        for (int i = 1; i <= 32; i++) begin
            step;
            if (i == 31) h = HOLD_MIN + int'(m_lfsr) * HOLD_STEP;
        end
        for (int j = 1; j < h; j++) step;
        chk("pre-abort tick", {31'd0, tick}, 32'd1);
        rst = 1'b1;
        #1;
        chk("abort tick", {31'd0, tick}, 32'd0);
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort lights_out", {31'd0, lights_out}, 32'd0);
        chk("abort tick_count", {28'd0, tick_count}, 32'd0);
        chk("abort lights", {24'd0, m_lights}, 32'd0);
        step;
        step;
        rst = 1'b0;
        idle_bad = 1'b0;
        for (int i = 0; i < 300; i++) begin
            step;
            if (tick || busy || lights_out || tick_count != 4'd0) idle_bad = 1'b1;
        end
        chk("idle after abort", {31'd0, idle_bad}, 32'd0);
        trigger = 1'b1;
        step;
        trigger = 1'b0;
        chk("restart busy", {31'd0, busy}, 32'd1);
        chk("restart tick_count", {28'd0, tick_count}, 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
